// File: rtl/life_pass_if.sv
// Control, video-read, init-write and engine-control signals of the life pass
// sequencer, bundled so the controller and its user connect through one port.
interface life_pass_if #(
  parameter int DBITS = 9
);
  logic              start;
  logic              run;
  logic              busy;
  logic              done;
  logic [31:0]       gen_count;
  logic              vid_req;
  logic [DBITS-2:0]  vid_row;
  logic              vid_gnt;
  logic              vid_valid;
  logic              init_valid;
  logic [DBITS-2:0]  init_row;
  logic              init_ready;
  logic [DBITS-1:0]  raddr;
  logic [DBITS-1:0]  waddr;
  logic              we;
  logic              sh;
  logic              ld;
  logic              init;

  // Host / video / init side: drives requests, observes engine controls.
  modport master (
    output start, run, vid_req, vid_row, init_valid, init_row,
    input  busy, done, gen_count, vid_gnt, vid_valid, init_ready,
    input  raddr, waddr, we, sh, ld, init
  );

  // Controller side.
  modport slave (
    input  start, run, vid_req, vid_row, init_valid, init_row,
    output busy, done, gen_count, vid_gnt, vid_valid, init_ready,
    output raddr, waddr, we, sh, ld, init
  );
endinterface

// File: rtl/life_pass_ctrl.sv
// Pass sequencer and read-port arbiter for the linear life engine.
// Reads bank cur_bank, writes the next generation into the other bank, then
// flips cur_bank. Video reads steal read cycles (never two in a row during a
// pass); init writes are accepted only while idle.
module life_pass_ctrl #(
  parameter int ROWS    = 256,
  parameter int DBITS   = 9,
  parameter int GENS    = 1,
  parameter int ROW_LAG = 2,
  parameter int WLAT    = 3
) (
  input  logic       clk,
  input  logic       reset,
  life_pass_if.slave bus
);
  localparam int RW = DBITS - 1;
  localparam int KW = DBITS + 1;
  localparam logic [KW-1:0] K_LAST   = KW'(ROWS + ROW_LAG - 1);
  localparam logic [KW-1:0] K_LAG    = KW'(ROW_LAG);
  localparam logic [RW-1:0] GEN_OFS  = RW'(GENS % ROWS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [31:0]   GEN_INC  = 32'(GENS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PASS  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]      state_reg, state_next;
  logic            cur_bank_reg;
  logic [KW-1:0]   k_reg;
  logic [RW-1:0]   wrow_reg;
  logic            last_gnt_reg;
  logic [WLAT-1:0] wr_pipe_reg, wr_pipe_next;
  logic [2:0]      vv_pipe_reg;
  logic            done_reg;
  logic [31:0]     gen_count_reg;

  logic in_pass, vid_gnt, init_ready, pass_rd, push_wr, pass_wr, last_wr;

  // Arbitration and pass read/write qualifiers for the current cycle.
  always_comb begin
    in_pass    = (state_reg == S_PASS);
    vid_gnt    = !reset && bus.vid_req && !(in_pass && last_gnt_reg);
    pass_rd    = in_pass && !vid_gnt;
    push_wr    = pass_rd && (k_reg >= K_LAG);
    pass_wr    = wr_pipe_reg[WLAT-1];
    last_wr    = pass_wr && (state_reg == S_DRAIN) && (wrow_reg == ROW_LAST);
    init_ready = !reset && bus.init_valid && (state_reg == S_IDLE) &&
                 !bus.start && !bus.run;
  end

  // Write-enable delay line: each qualifying sh becomes a write WLAT cycles later.
  generate
    for (genvar gi = 0; gi < WLAT; gi++) begin : g_wr_pipe
      if (gi == 0) begin : g_head
        assign wr_pipe_next[gi] = push_wr;
      end else begin : g_tail
        assign wr_pipe_next[gi] = wr_pipe_reg[gi-1];
      end
    end
  endgenerate

  // Next-state logic: IDLE -> PASS -> DRAIN -> PASS/IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (bus.start || bus.run) state_next = S_PASS;
      S_PASS:  if (pass_rd && (k_reg == K_LAST)) state_next = S_DRAIN;
      S_DRAIN: if (last_wr) state_next = bus.run ? S_PASS : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Sequencer state, counters, bank flip and pulse pipelines.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      cur_bank_reg  <= 1'b0;
      k_reg         <= '0;
      wrow_reg      <= '0;
      last_gnt_reg  <= 1'b0;
      wr_pipe_reg   <= '0;
      vv_pipe_reg   <= '0;
      done_reg      <= 1'b0;
      gen_count_reg <= '0;
    end else begin
      state_reg    <= state_next;
      last_gnt_reg <= in_pass && vid_gnt;
      wr_pipe_reg  <= wr_pipe_next;
      vv_pipe_reg  <= {vv_pipe_reg[1:0], vid_gnt};
      done_reg     <= last_wr;
      if (state_reg == S_IDLE) begin
        k_reg <= '0;
      end else if (pass_rd) begin
        k_reg <= (k_reg == K_LAST) ? '0 : k_reg + KW'(1);
      end
      // wrow wraps to 0 after ROWS-1 since ROWS is a power of 2
      if (pass_wr) wrow_reg <= wrow_reg + RW'(1);
      if (last_wr) begin
        cur_bank_reg  <= ~cur_bank_reg;
        gen_count_reg <= gen_count_reg + GEN_INC;
      end
    end
  end

  // Engine control and status outputs; idle values are all zero.
  always_comb begin
    bus.raddr = '0;
    bus.waddr = '0;
    if (vid_gnt) begin
      bus.raddr = {cur_bank_reg, bus.vid_row};
    end else if (pass_rd) begin
      bus.raddr = {cur_bank_reg, k_reg[RW-1:0] - GEN_OFS};
    end
    if (pass_wr) begin
      bus.waddr = {~cur_bank_reg, wrow_reg};
    end else if (init_ready) begin
      bus.waddr = {cur_bank_reg, bus.init_row};
    end
    bus.we         = pass_wr || init_ready;
    bus.sh         = pass_rd;
    bus.ld         = vid_gnt;
    bus.init       = init_ready;
    bus.vid_gnt    = vid_gnt;
    bus.vid_valid  = vv_pipe_reg[2];
    bus.init_ready = init_ready;
    bus.busy       = (state_reg != S_IDLE);
    bus.done       = done_reg;
    bus.gen_count  = gen_count_reg;
  end
endmodule

// File: tb/tb_life_pass_ctrl.sv
// Randomized scoreboard bench for life_pass_ctrl. The stimulus side predicts
// every read, write, grant, video-valid and done event (cycle + address) from
// the pass rules and queues it; the monitor pops and compares on each output.
module tb_life_pass_ctrl;
  localparam int ROWS    = 8;
  localparam int DBITS   = 4;
  localparam int GENS    = 1;
  localparam int ROW_LAG = 2;
  localparam int WLAT    = 3;
  localparam int VLAT    = 3;
  localparam int KN      = ROWS + ROW_LAG;

  typedef struct {
    int cyc;
    int val;
    bit ini;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  int   bank = 0;
  int   gen = 0;

  ev_t q_rd[$], q_wr[$], q_gnt[$], q_vv[$], q_done[$];

  life_pass_if #(.DBITS(DBITS)) bus ();

  life_pass_ctrl #(
    .ROWS(ROWS), .DBITS(DBITS), .GENS(GENS), .ROW_LAG(ROW_LAG), .WLAT(WLAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input int c, input int v, input bit i);
    ev_t e;
    e.cyc = c;
    e.val = v;
    e.ini = i;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the expected event whenever the DUT presents one.
  always @(negedge clk) begin : mon
    ev_t e;
    if (mon_en) begin
      if (bus.sh) begin
        if (q_rd.size() == 0) chk("rd_unexpected", 32'(cyc), 32'hffff_ffff);
        else begin
          e = q_rd.pop_front();
          chk("rd_cycle", 32'(cyc), 32'(e.cyc));
          chk("rd_addr", 32'(bus.raddr), 32'(e.val));
        end
      end
      if (bus.we) begin
        if (q_wr.size() == 0) chk("wr_unexpected", 32'(cyc), 32'hffff_ffff);
        else begin
          e = q_wr.pop_front();
          chk("wr_cycle", 32'(cyc), 32'(e.cyc));
          chk("wr_addr", 32'(bus.waddr), 32'(e.val));
          chk("wr_init", 32'(bus.init), 32'(e.ini));
          if (e.ini) chk("init_ready", 32'(bus.init_ready), 32'd1);
        end
      end
      if (bus.init_ready) chk("init_ready_busy", 32'(bus.busy), 32'd0);
      if (bus.vid_gnt) begin
        if (q_gnt.size() == 0) chk("gnt_unexpected", 32'(cyc), 32'hffff_ffff);
        else begin
          e = q_gnt.pop_front();
          chk("gnt_cycle", 32'(cyc), 32'(e.cyc));
          chk("gnt_raddr", 32'(bus.raddr), 32'(e.val));
          chk("gnt_ld", 32'(bus.ld), 32'd1);
          chk("gnt_sh", 32'(bus.sh), 32'd0);
        end
      end else if (bus.ld) begin
        chk("ld_without_gnt", 32'(bus.ld), 32'd0);
      end
      if (bus.vid_valid) begin
        if (q_vv.size() == 0) chk("vv_unexpected", 32'(cyc), 32'hffff_ffff);
        else begin
          e = q_vv.pop_front();
          chk("vid_valid_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (bus.done) begin
        if (q_done.size() == 0) chk("done_unexpected", 32'(cyc), 32'hffff_ffff);
        else begin
          e = q_done.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("gen_count", bus.gen_count, 32'(e.val));
          $display("pass done: cycle %0d gen_count %0d", cyc, bus.gen_count);
        end
      end
    end
  end

  // One or more passes (back-to-back via run when n>1) with vid_req asserted
  // pct% of cycles; optionally an init request held from the first PASS cycle.
  task automatic do_passes(input int n, input int pct, input bit use_run, input bit pend_init);
    int k, lastw, vr, ir;
    bit prev, r, g, inp;
    ir = $urandom_range(ROWS - 1);
    @(posedge clk); #1;
    if (use_run || n > 1) bus.run = 1'b1;
    else bus.start = 1'b1;
    bus.vid_req = 1'b0;
    for (int p = 0; p < n; p++) begin
      k = 0;
      prev = 1'b0;
      lastw = -1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (p == n - 1) bus.run = 1'b0;
      if (pend_init && p == 0) begin
        bus.init_valid = 1'b1;
        bus.init_row = (DBITS-1)'(ir);
      end
      forever begin
        r  = ($urandom_range(99) < pct);
        vr = $urandom_range(ROWS - 1);
        bus.vid_req = r;
        bus.vid_row = (DBITS-1)'(vr);
        inp = (k < KN);
        g   = r && !(inp && prev);
        if (g) begin
          q_gnt.push_back(mk(cyc, bank * ROWS + vr, 1'b0));
          q_vv.push_back(mk(cyc + VLAT, 0, 1'b0));
        end
        if (inp && !g) begin
          q_rd.push_back(mk(cyc, bank * ROWS + ((k - GENS + ROWS) % ROWS), 1'b0));
          if (k >= ROW_LAG) begin
            lastw = cyc + WLAT;
            q_wr.push_back(mk(lastw, (1 - bank) * ROWS + (k - ROW_LAG), 1'b0));
          end
          k++;
        end
        prev = inp && g;
        if (!inp && cyc == lastw) break;
        @(posedge clk); #1;
        bus.start = ($urandom_range(7) == 0);
      end
      gen += GENS;
      bank = 1 - bank;
      q_done.push_back(mk(lastw + 1, gen, 1'b0));
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.vid_req = 1'b0;
    if (pend_init) begin
      q_wr.push_back(mk(cyc, bank * ROWS + ir, 1'b1));
      $display("init write (held over pass): row %0d bank %0d", ir, bank);
      @(posedge clk); #1;
      bus.init_valid = 1'b0;
    end
  endtask

  task automatic init_write(input int row);
    @(posedge clk); #1;
    bus.init_valid = 1'b1;
    bus.init_row = (DBITS-1)'(row);
    q_wr.push_back(mk(cyc, bank * ROWS + row, 1'b1));
    $display("init write: row %0d bank %0d", row, bank);
    @(posedge clk); #1;
    bus.init_valid = 1'b0;
  endtask

  // Video reads while idle: granted every cycle, some alongside init writes.
  task automatic idle_video(input int n);
    int vr;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      vr = $urandom_range(ROWS - 1);
      bus.vid_req = 1'b1;
      bus.vid_row = (DBITS-1)'(vr);
      q_gnt.push_back(mk(cyc, bank * ROWS + vr, 1'b0));
      q_vv.push_back(mk(cyc + VLAT, 0, 1'b0));
      bus.init_valid = i[0];
      bus.init_row = (DBITS-1)'(ROWS - 1 - vr);
      if (i[0]) q_wr.push_back(mk(cyc, bank * ROWS + (ROWS - 1 - vr), 1'b1));
    end
    @(posedge clk); #1;
    bus.vid_req = 1'b0;
    bus.init_valid = 1'b0;
    repeat (VLAT + 1) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sh"}, 32'(bus.sh), 32'd0);
    chk({tag, "_we"}, 32'(bus.we), 32'd0);
    chk({tag, "_ld"}, 32'(bus.ld), 32'd0);
    chk({tag, "_init"}, 32'(bus.init), 32'd0);
    chk({tag, "_raddr"}, 32'(bus.raddr), 32'd0);
    chk({tag, "_waddr"}, 32'(bus.waddr), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_gen_count"}, bus.gen_count, 32'd0);
    chk({tag, "_vid_valid"}, 32'(bus.vid_valid), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.run = 1'b0;
    bus.vid_req = 1'b0;
    bus.vid_row = '0;
    bus.init_valid = 1'b0;
    bus.init_row = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    mon_en = 1'b1;

    // Blinker seed rows, then a plain pass (exact timing), then a second one.
    init_write(3);
    init_write(4);
    init_write(5);
    do_passes(1, 0, 1'b0, 1'b0);
    idle_video(3);
    do_passes(1, 0, 1'b0, 1'b0);
    // Video held high for a whole pass: grants alternate with reads.
    do_passes(1, 100, 1'b0, 1'b0);
    // run held for three back-to-back passes.
    do_passes(3, 0, 1'b1, 1'b0);
    // Init request raised during a pass waits for IDLE.
    do_passes(1, 20, 1'b0, 1'b1);
    idle_video(6);

    // Reset in the middle of a pass, then a fresh pass from bank 0.
    mon_en = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("midpass_reset");
    q_rd.delete();
    q_wr.delete();
    q_gnt.delete();
    q_vv.delete();
    q_done.delete();
    bank = 0;
    gen = 0;
    mon_en = 1'b1;
    do_passes(1, 0, 1'b0, 1'b0);

    // Randomized mixes of video load, pass counts and held init requests.
    for (int i = 0; i < 6; i++) begin
      do_passes(1 + $urandom_range(1), $urandom_range(80), 1'($urandom_range(1)),
                1'($urandom_range(1)));
    end

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rd_queue_empty", 32'(q_rd.size()), 32'd0);
    chk("wr_queue_empty", 32'(q_wr.size()), 32'd0);
    chk("gnt_queue_empty", 32'(q_gnt.size()), 32'd0);
    chk("vv_queue_empty", 32'(q_vv.size()), 32'd0);
    chk("done_queue_empty", 32'(q_done.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/life_pass_ctrl.md
Name: life_pass_ctrl

Overview:
- Sequencer and arbiter for the linear life engine datapath (cell RAM plus GENS-generation shift/compute pipeline).
- Runs generation passes over a toroidal ROWS-row image, ping-ponging between two RAM banks selected by the address MSB.
- Shares the RAM read port between pass reads and video row reads, and accepts init row writes while idle.

Parameters:
ROWS, 256, image height in rows (power of 2)
DBITS, 9, RAM address width = log2(ROWS)+1; MSB is the bank bit
GENS, 1, generations computed per pass
ROW_LAG, 2, shifts from reading read-index k until output row k-ROW_LAG is in mem_wdata (2*GENS for the engine)
WLAT, 3, cycles from an sh cycle to its write cycle

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  pulse: run one pass (ignored unless IDLE)
run  in  1  level: start passes back-to-back while high
busy  out  1  high in PASS or DRAIN
done  out  1  1-cycle pulse when a pass completes
gen_count  out  32  generations completed; wraps
vid_req  in  1  video row read request
vid_row  in  DBITS-1  video row index
vid_gnt  out  1  request accepted this cycle
vid_valid  out  1  engine dout holds the granted row
init_valid  in  1  init write request
init_row  in  DBITS-1  init row index (data goes to engine init_data)
init_ready  out  1  init write accepted this cycle
raddr  out  DBITS  engine read address
waddr  out  DBITS  engine write address
we  out  1  engine write enable
sh  out  1  engine shift enable
ld  out  1  engine video load
init  out  1  engine init-data select

Behaviour:
- Reset values: state IDLE, cur_bank 0, all counters 0, all outputs 0. Reset mid-pass aborts it: in-flight writes are dropped and the bank is not toggled.
- cur_bank holds the latest complete generation. Video reads and init writes target {cur_bank,row}.
- IDLE -> PASS on start or run. A pass reads from bank cur_bank and writes to bank ~cur_bank.
- PASS: issue read-index k = 0..ROWS+ROW_LAG-1 with raddr={cur_bank,(k-GENS) mod ROWS} and sh=1.
  - k advances only on sh cycles.
  - After the last index is issued -> DRAIN.
- Write stream:
  - An sh at cycle t with k>=ROW_LAG produces we=1 at cycle t+WLAT.
  - waddr={~cur_bank,wrow}; wrow counts 0..ROWS-1 and increments per write.
  - The delay is a fixed WLAT-deep shift of sh, independent of later stalls.
- DRAIN: wait until the final write issues.
  - In the next cycle: done=1, cur_bank toggles, gen_count += GENS.
  - Then -> PASS if run=1, else IDLE.
- Video arbitration:
  - vid_req has priority over pass reads. In a cycle with vid_gnt=1: sh=0, ld=1, raddr={cur_bank,vid_row}, and the pass stalls.
  - Anti-starvation: a grant cycle in PASS is always followed by one pass-read cycle, so vid_gnt is never granted on consecutive PASS cycles.
  - vid_gnt is combinational from vid_req and state. In IDLE/DRAIN a request is granted every cycle.
  - vid_valid pulses exactly 3 cycles after the vid_gnt cycle.
- Init:
  - init_ready = init_valid && state==IDLE && !start && !run.
  - On accept: we=1, init=1, waddr={cur_bank,init_row}.
  - An init write may coincide with a video grant (separate ports).
  - init_valid outside IDLE waits; it is never dropped.
- start or run arriving during PASS/DRAIN does not restart or extend the current pass.
- Outputs raddr, waddr, we, sh, ld, init are 0 whenever not driven by the rules above.

Test Plan:
1. ROWS=8, GENS=1, ROW_LAG=2, start at cycle 0.
   - Cycles 0-9: sh=1, raddr rows 7,0,1,...,7,0 (bank 0).
   - we at cycles 5-12 to bank-1 rows 0-7.
   - done at cycle 13; cur_bank=1; gen_count=1.
2. Blinker seeded by 3 init writes to rows 3/4/5 col 4, then start.
   - After done, video reads of rows 3-5 show a horizontal bar at cols 3-5 on row 4.
   - A second pass restores the vertical bar; gen_count=2.
3. vid_req held high throughout a pass.
   - Grants alternate with sh cycles; the pass takes 2x cycles.
   - Written data is identical to scenario 1; each vid_valid comes 3 cycles after its grant.
4. run held high for 3 passes.
   - Passes run back-to-back with no IDLE cycle; cur_bank sequence 1,0,1; three done pulses; gen_count=3.
5. Reset asserted at cycle 6 of a pass.
   - Next cycle all outputs are 0 and state is IDLE; cur_bank=0.
   - After release, a fresh start reproduces scenario 1 exactly.
6. init_valid asserted during PASS: init_ready stays 0 until IDLE, then the write is accepted in the first IDLE cycle with init=1.
